// File: rtl/m92_pkg.sv
// Shared definitions for the palette DMA sequencer.
//   pal_dma_state_t : sequencer states
//   PAL_AW          : palette RAM word-address width
package m92_pkg;

  localparam int PAL_AW = 13;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VBL = 3'd1,
    GRANT    = 3'd2,
    COPY     = 3'd3,
    FLUSH    = 3'd4,
    FIN      = 3'd5
  } pal_dma_state_t;

endpackage

// File: rtl/pal_dma_ctrl.sv
// Palette DMA sequencer: copies len words from the CPU palette staging buffer
// into palette RAM through the GA21 port, waiting for vertical blank first.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle transfer request (honoured only in IDLE)
//   len/src_base/dst_base  transfer parameters, latched on an accepted start
//   vblank              vertical blank
//   buf_addr / buf_q    staging-buffer read port (1-cycle read latency)
//   ga21_addr/we/req    palette RAM GA21 port
//   pal_din             palette RAM write data
//   dma_busy, done      status: busy from accept to completion, done pulse
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start
// WAIT_VBL | transfer accepted, waiting for vblank
// GRANT    | one cycle of ga21_req with no write, palette RAM mux settles
// COPY     | one buffer read issued per cycle, writes trail by one cycle
// FLUSH    | last write drains, no read issued
// FIN      | done pulse, port released
module pal_dma_ctrl
  import m92_pkg::*;
#(
  parameter int AW = PAL_AW,
  parameter int LW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic          vblank,
  output logic [AW-1:0] buf_addr,
  input  logic [15:0]   buf_q,
  output logic [AW-1:0] ga21_addr,
  output logic          ga21_we,
  output logic          ga21_req,
  output logic [15:0]   pal_din,
  output logic          dma_busy,
  output logic          done
);

  pal_dma_state_t state_q, state_d;

  logic [LW-1:0] n_q, n_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;

  // Read stage: buf_addr_q is the address presented to the buffer this cycle;
  // rd_vld_q/rd_dst_q say whether it is a real read and where it will land.
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic          rd_vld_q, rd_vld_d;
  logic [AW-1:0] rd_dst_q, rd_dst_d;

  // Write stage.
  logic [AW-1:0] ga21_addr_q, ga21_addr_d;
  logic          ga21_we_q, ga21_we_d;

  logic          ga21_req_q, ga21_req_d;
  logic          dma_busy_q, dma_busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    len_d       = len_q;
    src_d       = src_q;
    dst_d       = dst_q;
    buf_addr_d  = buf_addr_q;
    rd_vld_d    = 1'b0;
    rd_dst_d    = rd_dst_q;
    ga21_we_d   = rd_vld_q;
    ga21_addr_d = rd_vld_q ? rd_dst_q : ga21_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          src_d   = src_base;
          dst_d   = dst_base;
          n_d     = '0;
          state_d = WAIT_VBL;
        end
      end
      WAIT_VBL: begin
        if (vblank) state_d = GRANT;
      end
      GRANT: begin
        if (len_q == '0) begin
          state_d = FIN;
        end else begin
          // Word 0 is issued on entry to COPY so buf_addr is valid in COPY's first cycle.
          state_d    = COPY;
          buf_addr_d = src_q;
          rd_dst_d   = dst_q;
          rd_vld_d   = 1'b1;
          n_d        = LW'(1);
        end
      end
      COPY: begin
        // n_q counts words already issued; once it reaches len only the drain remains.
        if (n_q == len_q) begin
          state_d = FLUSH;
        end else begin
          buf_addr_d = src_q + AW'(n_q);
          rd_dst_d   = dst_q + AW'(n_q);
          rd_vld_d   = 1'b1;
          n_d        = n_q + LW'(1);
        end
      end
      FLUSH: state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ga21_req_d = (state_d == GRANT) || (state_d == COPY) || (state_d == FLUSH);
    dma_busy_d = ga21_req_d || (state_d == WAIT_VBL);
    done_d     = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      buf_addr_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_dst_q    <= '0;
      ga21_addr_q <= '0;
      ga21_we_q   <= 1'b0;
      ga21_req_q  <= 1'b0;
      dma_busy_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      len_q       <= len_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      buf_addr_q  <= buf_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_dst_q    <= rd_dst_d;
      ga21_addr_q <= ga21_addr_d;
      ga21_we_q   <= ga21_we_d;
      ga21_req_q  <= ga21_req_d;
      dma_busy_q  <= dma_busy_d;
      done_q      <= done_d;
    end
  end

  assign buf_addr  = buf_addr_q;
  assign ga21_addr = ga21_addr_q;
  assign ga21_we   = ga21_we_q;
  assign ga21_req  = ga21_req_q;
  assign dma_busy  = dma_busy_q;
  assign done      = done_q;

  // The staging buffer's output register is the data stage of the write
  // pipeline; it lines up with ga21_we_q, so it is forwarded rather than
  // re-registered. Masking keeps pal_din at zero whenever no write is issued.
  assign pal_din = ga21_we_q ? buf_q : 16'h0000;

endmodule

// File: tb/tb_pal_dma_ctrl.sv
module tb_pal_dma_ctrl;
  localparam int AW = 13;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic [AW-1:0] src_i = '0;
  logic [AW-1:0] dst_i = '0;
  logic          vblank_i = 1'b0;
  logic [AW-1:0] buf_addr;
  logic [15:0]   buf_q = 16'h0000;
  logic [AW-1:0] ga21_addr;
  logic          ga21_we;
  logic          ga21_req;
  logic [15:0]   pal_din;
  logic          dma_busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pal_dma_ctrl #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start_i), .len(len_i),
    .src_base(src_i), .dst_base(dst_i), .vblank(vblank_i),
    .buf_addr(buf_addr), .buf_q(buf_q), .ga21_addr(ga21_addr),
    .ga21_we(ga21_we), .ga21_req(ga21_req), .pal_din(pal_din),
    .dma_busy(dma_busy), .done(done)
  );

  function automatic logic [15:0] bufdata(input logic [AW-1:0] a);
    return {3'b101, a} ^ 16'h0F0F;
  endfunction

  // Staging buffer: 1-cycle registered read.
  always @(posedge clk) buf_q <= bufdata(buf_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a transfer cycle by cycle, relative to cycle 0 = start accepted with
  // vblank high. Inputs for cycle c0-1 must already be driven by the caller.
  // With disturb set, cycle 5 re-strobes start and drops vblank.
  task automatic xfer(input int l, input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input int c0, input bit disturb);
    int tdone;
    logic [AW-1:0] ea;
    tdone = (l == 0) ? 3 : 4 + l;
    for (int c = c0; c <= tdone + 1; c++) begin
      tick();
      start_i = 1'b0;
      if (disturb && c == 5) begin
        start_i  = 1'b1;
        len_i    = 12'd7;
        src_i    = 13'h0AAA;
        dst_i    = 13'h0BBB;
        vblank_i = 1'b0;
      end
      chk($sformatf("busy c%0d", c), 32'(dma_busy), 32'(c < tdone));
      chk($sformatf("req c%0d", c), 32'(ga21_req), 32'(c >= 2 && c < tdone));
      chk($sformatf("done c%0d", c), 32'(done), 32'(c == tdone));
      chk($sformatf("we c%0d", c), 32'(ga21_we), 32'(l > 0 && c >= 4 && c <= 3 + l));
      if (l > 0 && c >= 3 && c <= 2 + l) begin
        ea = s + AW'(c - 3);
        chk($sformatf("buf_addr c%0d", c), 32'(buf_addr), 32'(ea));
      end
      if (l > 0 && c >= 4 && c <= 3 + l) begin
        ea = d + AW'(c - 4);
        chk($sformatf("ga21_addr c%0d", c), 32'(ga21_addr), 32'(ea));
        ea = s + AW'(c - 4);
        chk($sformatf("pal_din c%0d", c), 32'(pal_din), 32'(bufdata(ea)));
      end
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst busy", 32'(dma_busy), 0);
    chk("rst req", 32'(ga21_req), 0);
    chk("rst we", 32'(ga21_we), 0);
    chk("rst done", 32'(done), 0);
    chk("rst buf_addr", 32'(buf_addr), 0);
    chk("rst ga21_addr", 32'(ga21_addr), 0);
    chk("rst pal_din", 32'(pal_din), 0);
    reset = 1'b0;
    tick();

    // Basic copy, vblank already high
    start_i = 1'b1; len_i = 12'd4; src_i = 13'h0010; dst_i = 13'h0800; vblank_i = 1'b1;
    xfer(4, 13'h0010, 13'h0800, 1, 1'b0);

    // Start outside vblank: nothing on the port until vblank rises
    start_i = 1'b1; len_i = 12'd2; src_i = 13'h0123; dst_i = 13'h0040; vblank_i = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      start_i = 1'b0;
      chk($sformatf("wait busy k%0d", k), 32'(dma_busy), 1);
      chk($sformatf("wait req k%0d", k), 32'(ga21_req), 0);
    end
    vblank_i = 1'b1;
    xfer(2, 13'h0123, 13'h0040, 2, 1'b0);

    // Address wrap at 8191
    start_i = 1'b1; len_i = 12'd3; src_i = 13'h1FFE; dst_i = 13'h1FFF;
    xfer(3, 13'h1FFE, 13'h1FFF, 1, 1'b0);

    // Zero length
    start_i = 1'b1; len_i = 12'd0; src_i = 13'h0005; dst_i = 13'h0006;
    xfer(0, 13'h0005, 13'h0006, 1, 1'b0);

    // Second start during COPY and vblank drop: ignored, no stall
    vblank_i = 1'b1;
    start_i = 1'b1; len_i = 12'd6; src_i = 13'h0300; dst_i = 13'h0700;
    xfer(6, 13'h0300, 13'h0700, 1, 1'b0 | 1'b1);
    vblank_i = 1'b1;
    tick();
    chk("no queued start", 32'(dma_busy), 0);

    // Reset mid-COPY
    start_i = 1'b1; len_i = 12'd8; src_i = 13'h0200; dst_i = 13'h0300;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start_i = 1'b0;
    end
    chk("pre-rst copy req", 32'(ga21_req), 1);
    chk("pre-rst copy we", 32'(ga21_we), 1);
    reset = 1'b1;
    tick();
    chk("mid rst busy", 32'(dma_busy), 0);
    chk("mid rst req", 32'(ga21_req), 0);
    chk("mid rst we", 32'(ga21_we), 0);
    chk("mid rst done", 32'(done), 0);
    chk("mid rst buf_addr", 32'(buf_addr), 0);
    chk("mid rst ga21_addr", 32'(ga21_addr), 0);
    chk("mid rst pal_din", 32'(pal_din), 0);
    reset = 1'b0;
    tick();
    chk("post rst busy", 32'(dma_busy), 0);
    chk("post rst we", 32'(ga21_we), 0);

    // Same as the first transfer after reset
    start_i = 1'b1; len_i = 12'd4; src_i = 13'h0010; dst_i = 13'h0800;
    xfer(4, 13'h0010, 13'h0800, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
